// File: rtl/counter_updn_mod_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
package counter_updn_mod_pkg;

   // Direction encodings for the 'up' input.
   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   // Largest value representable in w bits (2**w - 1).
   function automatic longint cnt_max(input int w);
      return (longint'(1) << w) - 1;
   endfunction

endpackage

// File: rtl/counter_updn_mod_next_val.sv
// Combinational next-count and terminal-count logic for the modulo-N counter.
module cnt_next_val
   import counter_updn_mod_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
)
(
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_up,
   output logic [WIDTH-1:0] o_next,
   output logic             o_tc
);

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

   // Wrap by explicit compare; values above MODULUS-1 fall back to 0 when counting up.
   always_comb begin
      o_next = i_q;
      o_tc   = 1'b0;
      if (i_up == CNT_UP) begin
         o_tc   = (i_q == LP_MAX);
         o_next = (i_q >= LP_MAX) ? '0 : i_q + WIDTH'(1);
      end else begin
         o_tc   = (i_q == '0);
         o_next = (i_q == '0) ? LP_MAX : i_q - WIDTH'(1);
      end
   end

endmodule

// File: rtl/counter_updn_mod.sv
// Parametrised modulo-N up/down counter with enable, load, cascade carry and wrap pulse.
module counter_updn_mod
   import counter_updn_mod_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16,
   parameter int INIT    = 0
)
(
   input  logic             clk,
   input  logic             clr,
   input  logic             sclr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             rco,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LP_INIT = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   LP_MOD  = (WIDTH + 1)'(MODULUS);

   if (WIDTH < 2) begin : g_bad_width
      $error("counter_updn_mod: WIDTH must be >= 2");
   end
   if (MODULUS < 2 || longint'(MODULUS) > cnt_max(WIDTH) + 1) begin : g_bad_modulus
      $error("counter_updn_mod: MODULUS must lie in 2..2**WIDTH");
   end
   if (INIT < 0 || INIT >= MODULUS) begin : g_bad_init
      $error("counter_updn_mod: INIT must be below MODULUS");
   end

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic [WIDTH-1:0] w_next;
   logic             w_tc;
   logic [WIDTH-1:0] w_load_val;

   cnt_next_val #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .i_q    (r_q),
      .i_up   (up),
      .o_next (w_next),
      .o_tc   (w_tc)
   );

   // Load values beyond the count range clamp to the top count.
   always_comb begin
      w_load_val = ({1'b0, d} >= LP_MOD) ? LP_MAX : d;
   end

   // Count register and wrap pulse; priority sclr > load > en > hold.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_q    <= LP_INIT;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= en & w_tc & ~load & ~sclr;
         if (sclr) begin
            r_q <= LP_INIT;
         end else if (load) begin
            r_q <= w_load_val;
         end else if (en) begin
            r_q <= w_next;
         end
      end
   end

   assign q    = r_q;
   assign wrap = r_wrap;
   assign tc   = w_tc;
   // Zero-latency carry so chained stages advance on the same edge.
   assign rco  = en & w_tc;

endmodule

// File: tb/tb_counter_updn_mod.sv
// Self-checking bench for counter_updn_mod: single stage, two-stage cascade, full-range variant.
module tb_counter_updn_mod;

   typedef struct packed {
      logic [3:0] q;
      logic       wrap;
      logic       tc;
      logic       rco;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr;
   // Main instance (MODULUS=10)
   logic       sclr, en, up, load;
   logic [3:0] d;
   logic [3:0] q;
   logic       tc, rco, wrap;
   // Cascade pair (MODULUS=10)
   logic       c_sclr, c_en, c_up;
   logic [3:0] ql, qh;
   logic       tcl, tch, rcol, rcoh, wl, wh;
   // Full-range instance (MODULUS=16)
   logic       f_sclr, f_en, f_up, f_load;
   logic [3:0] f_d;
   logic [3:0] f_q;
   logic       f_tc, f_rco, f_wrap;

   exp_t       sb[$];
   logic [11:0] csb[$];
   int         n_cmp = 0;
   int         n_mis = 0;

   always #5 clk = ~clk;

   counter_updn_mod #(.WIDTH(4), .MODULUS(10), .INIT(0)) dut (
      .clk(clk), .clr(clr), .sclr(sclr), .en(en), .up(up), .load(load), .d(d),
      .q(q), .tc(tc), .rco(rco), .wrap(wrap)
   );

   counter_updn_mod #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_lo (
      .clk(clk), .clr(clr), .sclr(c_sclr), .en(c_en), .up(c_up), .load(1'b0), .d(4'd0),
      .q(ql), .tc(tcl), .rco(rcol), .wrap(wl)
   );

   counter_updn_mod #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_hi (
      .clk(clk), .clr(clr), .sclr(c_sclr), .en(rcol), .up(c_up), .load(1'b0), .d(4'd0),
      .q(qh), .tc(tch), .rco(rcoh), .wrap(wh)
   );

   counter_updn_mod #(.WIDTH(4), .MODULUS(16), .INIT(0)) u_full (
      .clk(clk), .clr(clr), .sclr(f_sclr), .en(f_en), .up(f_up), .load(f_load), .d(f_d),
      .q(f_q), .tc(f_tc), .rco(f_rco), .wrap(f_wrap)
   );

   task automatic test_reset();
      exp_t e;
      // Reset asserted from time zero with up=0: INIT=0 so tc must be high.
      #3;
      sb.push_back('{q: 4'd0, wrap: 1'b0, tc: 1'b1, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL reset_init: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                  q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
      end
      // Hold reset across edges while trying to count.
      @(negedge clk); en = 1'b1; up = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         sb.push_back('{q: 4'd0, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
         e = sb.pop_front(); n_cmp++;
         if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
            n_mis++;
            $display("FAIL reset_hold[%0d]: got q=%0d wrap=%b, want q=%0d wrap=%b", i, q, wrap, e.q, e.wrap);
         end
      end
      // Release, load 7, then assert reset mid-cycle.
      @(negedge clk); clr = 1'b1; en = 1'b0; load = 1'b1; d = 4'd7;
      @(posedge clk); #1;
      sb.push_back('{q: 4'd7, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL reset_load7: got q=%0d, want q=%0d", q, e.q);
      end
      @(negedge clk); load = 1'b0; d = 4'd0;
      #2 clr = 1'b0;
      #1;
      sb.push_back('{q: 4'd0, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL reset_async: got q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, e.q, e.wrap);
      end
      @(negedge clk); clr = 1'b1;
   endtask

   task automatic test_up_wrap();
      exp_t e;
      logic [3:0] v;
      @(negedge clk); sclr = 1'b1;
      @(posedge clk);
      @(negedge clk); sclr = 1'b0; en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         v = 4'(k % 10);
         sb.push_back('{q: v, wrap: (k == 10), tc: (v == 4'd9), rco: (v == 4'd9)});
         e = sb.pop_front(); n_cmp++;
         if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
            n_mis++;
            $display("FAIL up_wrap[%0d]: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                     k, q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
         end
      end
      @(negedge clk); en = 1'b0;
   endtask

   task automatic test_down_dir();
      exp_t e;
      @(negedge clk); load = 1'b1; d = 4'd2; up = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      sb.push_back('{q: 4'd2, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      @(negedge clk); load = 1'b0; en = 1'b1;
      sb.push_back('{q: 4'd1, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      sb.push_back('{q: 4'd0, wrap: 1'b0, tc: 1'b1, rco: 1'b1});
      sb.push_back('{q: 4'd9, wrap: 1'b1, tc: 1'b0, rco: 1'b0});
      sb.push_back('{q: 4'd8, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL down_load2: got q=%0d, want q=%0d", q, e.q);
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         e = sb.pop_front(); n_cmp++;
         if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
            n_mis++;
            $display("FAIL down_step[%0d]: got q=%0d wrap=%b tc=%b rco=%b, want q=%0d wrap=%b tc=%b rco=%b",
                     k, q, wrap, tc, rco, e.q, e.wrap, e.tc, e.rco);
         end
      end
      // Flip to up at q=8: next edge gives 9 with tc high.
      @(negedge clk); up = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{q: 4'd9, wrap: 1'b0, tc: 1'b1, rco: 1'b1});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL dir_flip_up: got q=%0d tc=%b rco=%b, want q=%0d tc=%b rco=%b", q, tc, rco, e.q, e.tc, e.rco);
      end
      // Combinational re-evaluation of tc when direction changes with q=9.
      @(negedge clk); up = 1'b0; en = 1'b0;
      #1;
      sb.push_back('{q: 4'd9, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL dir_flip_tc: got tc=%b rco=%b, want tc=%b rco=%b", tc, rco, e.tc, e.rco);
      end
   endtask

   task automatic test_priority();
      exp_t e;
      @(negedge clk); load = 1'b1; d = 4'd5; en = 1'b0; up = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{q: 4'd5, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      // sclr, load and en together at q=5.
      @(negedge clk); sclr = 1'b1; load = 1'b1; d = 4'd3; en = 1'b1;
      sb.push_back('{q: 4'd0, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL prio_load5: got q=%0d, want q=%0d", q, e.q);
      end
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL prio_sclr: got q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, e.q, e.wrap);
      end
      // Clamp of out-of-range load value.
      @(negedge clk); sclr = 1'b0; load = 1'b1; d = 4'd13; en = 1'b0;
      @(posedge clk); #1;
      sb.push_back('{q: 4'd9, wrap: 1'b0, tc: 1'b1, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL load_clamp: got q=%0d tc=%b rco=%b, want q=%0d tc=%b rco=%b", q, tc, rco, e.q, e.tc, e.rco);
      end
      // Load beats en at terminal count; wrap must stay low.
      @(negedge clk); load = 1'b1; d = 4'd9; en = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{q: 4'd9, wrap: 1'b0, tc: 1'b1, rco: 1'b1});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL load_over_en: got q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, e.q, e.wrap);
      end
      // sclr at terminal count with en also suppresses wrap.
      @(negedge clk); load = 1'b0; sclr = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{q: 4'd0, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({q, wrap, tc, rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL sclr_at_tc: got q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, e.q, e.wrap);
      end
      @(negedge clk); sclr = 1'b0; en = 1'b0; d = 4'd0;
   endtask

   task automatic test_cascade();
      logic [11:0] ce;
      logic [3:0]  lo, hi;
      @(negedge clk); c_sclr = 1'b1; c_en = 1'b0; c_up = 1'b1;
      @(posedge clk); #1;
      csb.push_back({4'd0, 4'd0, 4'b0000});
      ce = csb.pop_front(); n_cmp++;
      if ({qh, ql, wh, wl, rcoh, rcol} !== ce) begin
         n_mis++;
         $display("FAIL cascade_clear: got %0d:%0d, want %0d:%0d", qh, ql, ce[11:8], ce[7:4]);
      end
      @(negedge clk); c_sclr = 1'b0; c_en = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         lo = 4'(k % 10);
         hi = 4'((k / 10) % 10);
         csb.push_back({hi, lo, (k == 100), (k % 10 == 0), (hi == 4'd9 && lo == 4'd9), (lo == 4'd9)});
         ce = csb.pop_front(); n_cmp++;
         if ({qh, ql, wh, wl, rcoh, rcol} !== ce) begin
            n_mis++;
            $display("FAIL cascade[%0d]: got %0d:%0d wrap=%b%b rco=%b%b, want %0d:%0d wrap=%b%b rco=%b%b",
                     k, qh, ql, wh, wl, rcoh, rcol, ce[11:8], ce[7:4], ce[3], ce[2], ce[1], ce[0]);
         end
      end
      @(negedge clk); c_en = 1'b0;
   endtask

   task automatic test_full_range();
      exp_t e;
      @(negedge clk); f_sclr = 1'b1; f_up = 1'b0; f_en = 1'b0;
      @(posedge clk);
      @(negedge clk); f_sclr = 1'b0; f_en = 1'b1;
      #1;
      sb.push_back('{q: 4'd0, wrap: 1'b0, tc: 1'b1, rco: 1'b1});
      e = sb.pop_front(); n_cmp++;
      if ({f_q, f_wrap, f_tc, f_rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL full_zero: got q=%0d tc=%b rco=%b, want q=%0d tc=%b rco=%b", f_q, f_tc, f_rco, e.q, e.tc, e.rco);
      end
      @(posedge clk); #1;
      sb.push_back('{q: 4'd15, wrap: 1'b1, tc: 1'b0, rco: 1'b0});
      e = sb.pop_front(); n_cmp++;
      if ({f_q, f_wrap, f_tc, f_rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
         n_mis++;
         $display("FAIL full_down_wrap: got q=%0d wrap=%b, want q=%0d wrap=%b", f_q, f_wrap, e.q, e.wrap);
      end
      @(negedge clk); f_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         sb.push_back('{q: 4'd15, wrap: 1'b0, tc: 1'b0, rco: 1'b0});
         e = sb.pop_front(); n_cmp++;
         if ({f_q, f_wrap, f_tc, f_rco} !== {e.q, e.wrap, e.tc, e.rco}) begin
            n_mis++;
            $display("FAIL full_hold[%0d]: got q=%0d wrap=%b, want q=%0d wrap=%b", k, f_q, f_wrap, e.q, e.wrap);
         end
      end
   endtask

   initial begin
      clr = 1'b0; sclr = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; d = 4'd0;
      c_sclr = 1'b0; c_en = 1'b0; c_up = 1'b1;
      f_sclr = 1'b0; f_en = 1'b0; f_up = 1'b0; f_load = 1'b0; f_d = 4'd0;
      test_reset();
      test_up_wrap();
      test_down_dir();
      test_priority();
      test_cascade();
      test_full_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
